// File: rtl/soin_pkg.sv
// rtl/soin_pkg.sv - shared types and sizes for the operand fetch slice
// Purpose: word/register widths, the register-number and data types, and the
//          ID/EX payload layout shared by the stage, its scoreboard and interface.
// Ports:   none (package).
package soin_pkg;

   localparam int WORD_SIZE = 32;
   localparam int NUM_REGS  = 32;
   localparam int REG_W     = $clog2(NUM_REGS);

   typedef logic [WORD_SIZE-1:0] data_t;
   typedef logic [REG_W-1:0]     reg_t;

   // Contents of the ID/EX register handed to the execute stage.
   typedef struct packed {
      data_t op1;
      data_t op2;
      reg_t  rd;
      logic  wen;
      data_t pc;
   } idex_t;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// rtl/operand_fetch_stage_if.sv - bundle of all operand fetch stage bus signals
// Purpose: groups the upstream handshake, register-file read port, writeback
//          bypass, flush and downstream ID/EX handshake into one interface.
// Ports:   none; modport slave is the stage's view, master the driver's view.
interface operand_fetch_stage_if;
   import soin_pkg::*;

   // upstream instruction
   logic  i_valid;
   logic  o_ready;
   reg_t  i_rs1;
   reg_t  i_rs2;
   reg_t  i_rd;
   logic  i_wen;
   data_t i_pc;
   // register file read port
   reg_t  o_Rnum1;
   reg_t  o_Rnum2;
   data_t i_Rd1;
   data_t i_Rd2;
   // writeback (also drives the register file)
   logic  i_wb_en;
   reg_t  i_wb_num;
   data_t i_wb_data;
   // squash
   logic  i_flush;
   // downstream ID/EX register
   logic  o_valid;
   logic  i_ready;
   data_t o_op1;
   data_t o_op2;
   reg_t  o_rd;
   logic  o_wen;
   data_t o_pc;

   modport slave (
      input  i_valid, i_rs1, i_rs2, i_rd, i_wen, i_pc,
      input  i_Rd1, i_Rd2,
      input  i_wb_en, i_wb_num, i_wb_data,
      input  i_flush, i_ready,
      output o_ready, o_Rnum1, o_Rnum2,
      output o_valid, o_op1, o_op2, o_rd, o_wen, o_pc
   );

   modport master (
      output i_valid, i_rs1, i_rs2, i_rd, i_wen, i_pc,
      output i_Rd1, i_Rd2,
      output i_wb_en, i_wb_num, i_wb_data,
      output i_flush, i_ready,
      input  o_ready, o_Rnum1, o_Rnum2,
      input  o_valid, o_op1, o_op2, o_rd, o_wen, o_pc
   );

endinterface

// File: rtl/operand_fetch_stage_scoreboard.sv
// rtl/operand_fetch_stage_scoreboard.sv - pending-write register scoreboard
// Purpose: one pending bit per architectural register, set when a writer issues
//          and cleared on its writeback. x0 is never marked pending.
// Ports:   i_clk, i_rstn (async active-low); i_set_en/i_set_num set a bit;
//          i_clr_en/i_clr_num clear a bit; i_q_rs1/i_q_rs2/i_q_rd are
//          combinational queries answered on o_p_rs1/o_p_rs2/o_p_rd.
module reg_scoreboard
   import soin_pkg::*;
(
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_set_en,
   input  reg_t i_set_num,
   input  logic i_clr_en,
   input  reg_t i_clr_num,
   input  reg_t i_q_rs1,
   input  reg_t i_q_rs2,
   input  reg_t i_q_rd,
   output logic o_p_rs1,
   output logic o_p_rs2,
   output logic o_p_rd
);

   logic [NUM_REGS-1:0] pending_q;
   logic [NUM_REGS-1:0] pending_d;

   // Set is applied after clear so a register that issues and writes back in
   // the same cycle stays pending for the newer writer.
   always_comb begin
      pending_d = pending_q;
      if (i_clr_en && (i_clr_num != '0)) begin
         pending_d[i_clr_num] = 1'b0;
      end
      if (i_set_en && (i_set_num != '0)) begin
         pending_d[i_set_num] = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign o_p_rs1 = pending_q[i_q_rs1];
   assign o_p_rs2 = pending_q[i_q_rs2];
   assign o_p_rd  = pending_q[i_q_rd];

endmodule

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - decode/operand fetch stage with hazard stall and bypass
// Purpose: drives the register-file read addresses, forwards same-cycle writeback
//          data, stalls on RAW/WAW hazards against in-flight writers, and loads a
//          one-entry ID/EX register under a valid/ready handshake.
// Ports:   i_clk, i_rstn (async active-low); bus (operand_fetch_stage_if.slave):
//          upstream i_valid/o_ready + rs1/rs2/rd/wen/pc, register-file
//          o_Rnum*/i_Rd*, writeback i_wb_*, i_flush, downstream o_valid/i_ready
//          + op1/op2/rd/wen/pc.
module operand_fetch_stage
   import soin_pkg::*;
#(
   parameter bit WB_BYPASS_EN = 1'b1
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   operand_fetch_stage_if.slave    bus
);

   idex_t idex_q, idex_d;
   logic  valid_q, valid_d;

   logic  issue;
   logic  p_rs1, p_rs2, p_rd;
   logic  wb_hit1, wb_hit2;
   logic  hz1, hz2, hz_waw, hazard;
   logic  ready;
   logic  load;
   data_t op1, op2;

   assign issue = valid_q & bus.i_ready;

   reg_scoreboard u_sb (
      .i_clk     (i_clk),
      .i_rstn    (i_rstn),
      .i_set_en  (issue & idex_q.wen),
      .i_set_num (idex_q.rd),
      .i_clr_en  (bus.i_wb_en),
      .i_clr_num (bus.i_wb_num),
      .i_q_rs1   (bus.i_rs1),
      .i_q_rs2   (bus.i_rs2),
      .i_q_rd    (bus.i_rd),
      .o_p_rs1   (p_rs1),
      .o_p_rs2   (p_rs2),
      .o_p_rd    (p_rd)
   );

   // With bypass disabled a same-cycle writeback does not resolve the pending
   // bit; the bit clears at the edge and the register file serves it next cycle.
   assign wb_hit1 = WB_BYPASS_EN && bus.i_wb_en && (bus.i_wb_num == bus.i_rs1);
   assign wb_hit2 = WB_BYPASS_EN && bus.i_wb_en && (bus.i_wb_num == bus.i_rs2);

   // A writer stuck in ID/EX (not issuing) has not yet marked its rd pending,
   // so it is checked directly.
   assign hz1 = (bus.i_rs1 != '0) &&
                ((p_rs1 && !wb_hit1) ||
                 (valid_q && idex_q.wen && (idex_q.rd == bus.i_rs1) && !bus.i_ready));
   assign hz2 = (bus.i_rs2 != '0) &&
                ((p_rs2 && !wb_hit2) ||
                 (valid_q && idex_q.wen && (idex_q.rd == bus.i_rs2) && !bus.i_ready));
   // WAW ignores the bypass: the older writeback must retire before a new writer
   // to the same register may enter.
   assign hz_waw = bus.i_wen && (bus.i_rd != '0) &&
                   (p_rd || (valid_q && idex_q.wen && (idex_q.rd == bus.i_rd)));
   assign hazard = hz1 || hz2 || hz_waw;

   assign ready = (!valid_q || bus.i_ready) && !hazard && !bus.i_flush;
   assign load  = bus.i_valid && ready;

   always_comb begin
      op1 = '0;
      if (bus.i_rs1 != '0) begin
         op1 = wb_hit1 ? bus.i_wb_data : bus.i_Rd1;
      end
      op2 = '0;
      if (bus.i_rs2 != '0) begin
         op2 = wb_hit2 ? bus.i_wb_data : bus.i_Rd2;
      end
   end

   // Payload only changes on load, so it is stable while o_valid & !i_ready.
   always_comb begin
      valid_d = valid_q;
      idex_d  = idex_q;
      if (bus.i_flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d     = 1'b1;
         idex_d.op1  = op1;
         idex_d.op2  = op2;
         idex_d.rd   = bus.i_rd;
         idex_d.wen  = bus.i_wen && (bus.i_rd != '0);
         idex_d.pc   = bus.i_pc;
      end else if (issue) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         valid_q <= 1'b0;
         idex_q  <= '0;
      end else begin
         valid_q <= valid_d;
         idex_q  <= idex_d;
      end
   end

   assign bus.o_ready = ready;
   assign bus.o_Rnum1 = bus.i_rs1;
   assign bus.o_Rnum2 = bus.i_rs2;
   assign bus.o_valid = valid_q;
   assign bus.o_op1   = idex_q.op1;
   assign bus.o_op2   = idex_q.op2;
   assign bus.o_rd    = idex_q.rd;
   assign bus.o_wen   = idex_q.wen;
   assign bus.o_pc    = idex_q.pc;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - self-checking bench for operand_fetch_stage
module tb_operand_fetch_stage;
   import soin_pkg::*;

   typedef struct {
      data_t op1;
      data_t op2;
      reg_t  rd;
      logic  wen;
      data_t pc;
   } exp_t;

   logic clk;
   logic rstn;
   int   total;
   int   bad;
   exp_t exp_q[$];
   exp_t cur_exp;
   data_t rf [NUM_REGS];

   operand_fetch_stage_if bus ();

   operand_fetch_stage #(.WB_BYPASS_EN(1'b1)) dut (
      .i_clk  (clk),
      .i_rstn (rstn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.i_Rd1 = rf[bus.o_Rnum1];
   assign bus.i_Rd2 = rf[bus.o_Rnum2];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input reg_t rs1, input reg_t rs2, input reg_t rd, input logic wen,
                          input data_t pc, input data_t e1, input data_t e2, input logic ewen);
      bus.i_valid = 1'b1;
      bus.i_rs1   = rs1;
      bus.i_rs2   = rs2;
      bus.i_rd    = rd;
      bus.i_wen   = wen;
      bus.i_pc    = pc;
      cur_exp     = '{op1: e1, op2: e2, rd: rd, wen: ewen, pc: pc};
   endtask

   // Scoreboard: pop/compare on issue, drop on flush of a held entry, push on accept.
   always @(negedge clk) begin
      if (rstn) begin
         if (bus.o_valid && bus.i_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_issue", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sb_op1", bus.o_op1, e.op1);
               check("sb_op2", bus.o_op2, e.op2);
               check("sb_rd",  32'(bus.o_rd), 32'(e.rd));
               check("sb_wen", 32'(bus.o_wen), 32'(e.wen));
               check("sb_pc",  bus.o_pc, e.pc);
            end
         end else if (bus.i_flush && bus.o_valid && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
         end
         if (bus.i_valid && bus.o_ready) begin
            exp_q.push_back(cur_exp);
         end
      end
   end

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] = 32'h100 + i;
      rf[0] = 32'h99;
      rf[1] = 32'd5;
      rf[2] = 32'd7;
      rf[3] = 32'h11;
      rstn          = 1'b0;
      bus.i_valid   = 1'b0;
      bus.i_rs1     = '0;
      bus.i_rs2     = '0;
      bus.i_rd      = '0;
      bus.i_wen     = 1'b0;
      bus.i_pc      = '0;
      bus.i_wb_en   = 1'b0;
      bus.i_wb_num  = '0;
      bus.i_wb_data = '0;
      bus.i_flush   = 1'b0;
      bus.i_ready   = 1'b1;
      cur_exp       = '{op1: 0, op2: 0, rd: 0, wen: 0, pc: 0};

      // reset state
      @(negedge clk);
      check("rst_valid", 32'(bus.o_valid), 32'd0);
      check("rst_ready", 32'(bus.o_ready), 32'd1);
      check("rst_op1", bus.o_op1, 32'd0);
      check("rst_op2", bus.o_op2, 32'd0);
      check("rst_rd", 32'(bus.o_rd), 32'd0);
      check("rst_wen", 32'(bus.o_wen), 32'd0);
      check("rst_pc", bus.o_pc, 32'd0);
      tick();
      rstn = 1'b1;

      // basic fetch
      present(1, 2, 5, 1'b0, 32'h100, 32'd5, 32'd7, 1'b0);
      @(negedge clk); check("t1_ready", 32'(bus.o_ready), 32'd1);
      tick(); bus.i_valid = 1'b0;
      @(negedge clk); check("t1_valid", 32'(bus.o_valid), 32'd1);
      tick();

      // RAW on rd=3 resolved by writeback bypass
      present(0, 0, 3, 1'b1, 32'h104, 32'd0, 32'd0, 1'b1);
      @(negedge clk); check("t2_w_ready", 32'(bus.o_ready), 32'd1);
      tick(); bus.i_valid = 1'b0;
      @(negedge clk);
      tick();
      present(3, 2, 6, 1'b0, 32'h108, 32'hAB, 32'd7, 1'b0);
      @(negedge clk); check("raw_stall0", 32'(bus.o_ready), 32'd0);
      tick();
      @(negedge clk); check("raw_stall1", 32'(bus.o_ready), 32'd0);
      tick();
      bus.i_wb_en = 1'b1; bus.i_wb_num = 3; bus.i_wb_data = 32'hAB;
      @(negedge clk); check("raw_bypass", 32'(bus.o_ready), 32'd1);
      tick(); bus.i_wb_en = 1'b0; bus.i_valid = 1'b0;
      @(negedge clk);
      tick();

      // rd=0 writer and x0 reads
      present(0, 1, 0, 1'b1, 32'h10C, 32'd0, 32'd5, 1'b0);
      @(negedge clk); check("x0_ready", 32'(bus.o_ready), 32'd1);
      tick(); bus.i_valid = 1'b0;
      @(negedge clk); check("x0_wen", 32'(bus.o_wen), 32'd0);
      tick();
      present(0, 0, 7, 1'b0, 32'h110, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      check("x0_nostall", 32'(bus.o_ready), 32'd1);
      check("x0_pend", dut.u_sb.pending_q, 32'd0);
      tick(); bus.i_valid = 1'b0;
      @(negedge clk);
      tick();

      // hold with i_ready=0, then flush
      bus.i_ready = 1'b0;
      present(1, 2, 8, 1'b1, 32'h114, 32'd5, 32'd7, 1'b1);
      @(negedge clk); check("hold_load", 32'(bus.o_ready), 32'd1);
      tick(); bus.i_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(bus.o_valid), 32'd1);
         check("hold_op1", bus.o_op1, 32'd5);
         check("hold_op2", bus.o_op2, 32'd7);
         check("hold_pc", bus.o_pc, 32'h114);
         check("hold_ready", 32'(bus.o_ready), 32'd0);
         tick();
      end
      bus.i_flush = 1'b1;
      present(0, 0, 12, 1'b0, 32'h118, 32'd0, 32'd0, 1'b0);
      @(negedge clk); check("flush_ready", 32'(bus.o_ready), 32'd0);
      tick(); bus.i_flush = 1'b0; bus.i_valid = 1'b0;
      @(negedge clk);
      check("flush_valid", 32'(bus.o_valid), 32'd0);
      check("flush_pend", dut.u_sb.pending_q, 32'd0);
      tick();

      // WAW and set-wins-over-clear on rd=4
      present(0, 0, 4, 1'b1, 32'h120, 32'd0, 32'd0, 1'b1);
      @(negedge clk); check("waw_a_ready", 32'(bus.o_ready), 32'd1);
      tick();
      present(0, 0, 4, 1'b1, 32'h124, 32'd0, 32'd0, 1'b1);
      @(negedge clk); check("waw_b_ready", 32'(bus.o_ready), 32'd0);
      tick();
      bus.i_valid = 1'b0; bus.i_ready = 1'b1;
      bus.i_wb_en = 1'b1; bus.i_wb_num = 4; bus.i_wb_data = 32'h44;
      @(negedge clk);
      tick(); bus.i_wb_en = 1'b0;
      present(4, 0, 9, 1'b0, 32'h128, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      check("set_wins_raw", 32'(bus.o_ready), 32'd0);
      check("set_wins_pend", 32'(dut.u_sb.pending_q[4]), 32'd1);
      tick();
      present(0, 0, 4, 1'b1, 32'h12C, 32'd0, 32'd0, 1'b1);
      @(negedge clk); check("waw_stall", 32'(bus.o_ready), 32'd0);
      tick();
      bus.i_wb_en = 1'b1; bus.i_wb_num = 4; bus.i_wb_data = 32'h55;
      @(negedge clk); check("waw_nobypass", 32'(bus.o_ready), 32'd0);
      tick(); bus.i_wb_en = 1'b0;
      @(negedge clk); check("waw_release", 32'(bus.o_ready), 32'd1);
      tick(); bus.i_valid = 1'b0;
      @(negedge clk);
      tick();

      // asynchronous reset with pending state and a held entry
      bus.i_ready = 1'b0;
      present(1, 0, 10, 1'b1, 32'h130, 32'd5, 32'd0, 1'b1);
      @(negedge clk); check("e_ready", 32'(bus.o_ready), 32'd1);
      tick(); bus.i_valid = 1'b0;
      check("pre_valid", 32'(bus.o_valid), 32'd1);
      check("pre_pend4", 32'(dut.u_sb.pending_q[4]), 32'd1);
      #1 rstn = 1'b0;
      #1;
      check("arst_valid", 32'(bus.o_valid), 32'd0);
      check("arst_pend", dut.u_sb.pending_q, 32'd0);
      check("arst_pc", bus.o_pc, 32'd0);
      exp_q.delete();
      tick();
      rstn = 1'b1;
      bus.i_ready = 1'b1;
      present(4, 0, 13, 1'b0, 32'h134, 32'h104, 32'd0, 1'b0);
      @(negedge clk); check("post_rst_ready", 32'(bus.o_ready), 32'd1);
      tick(); bus.i_valid = 1'b0;
      @(negedge clk);
      tick();

      check("sb_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
